// File: rtl/watch_mode_ctrl.sv
// Watch front end: key debounce, display mode sequencing, short/long key events, alarm ring/snooze.
// Define WATCH_REPEAT_EN to re-pulse evt_long every REPEAT_CYC cycles while a key stays held.
module watch_mode_ctrl #(
  parameter int DEB_CYC    = 500000,
  parameter int LONG_CYC   = 100000000,
  parameter int REPEAT_CYC = 12500000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic [2:0] KEY,
  input  logic       sec_tick,
  input  logic       alarm_match,
  output logic [1:0] mode,
  output logic [1:0] evt_short,
  output logic [1:0] evt_long,
  output logic       ringing,
  output logic       ring_led,
  output logic [1:0] hex_sel
);

  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam int LW   = $clog2(LONG_CYC + 1);
  localparam int SMAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int SW   = $clog2(SMAX + 1);

  typedef enum logic [1:0] {K_IDLE, K_PRESS, K_HELD, K_WAIT} kst_e;
  typedef enum logic [1:0] {R_OFF, R_RING, R_SNOOZE} rst_e;

  logic [2:0]         sync1_q, sync2_q, deb_q, deb_d, debp_q;
  logic [2:0][DW-1:0] dcnt_q, dcnt_d;
  logic               am_q, amp_q;
  logic [2:0]         press, consume;
  logic               rise, mchg;

  kst_e               kst_q [2];
  kst_e               kst_d [2];
  logic [1:0][LW-1:0] kcnt_q, kcnt_d;
  logic [1:0]         es_q, es_d, el_q, el_d;
  logic [1:0]         mode_q, mode_d, hex_q;

  rst_e               rs_q, rs_d;
  logic [SW-1:0]      scnt_q, scnt_d;
  logic               led_q, led_d, ring_q;

`ifdef WATCH_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC + 1);
  logic [1:0][RW-1:0] rpt_q, rpt_d;
`endif

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      deb_d[k]  = deb_q[k];
      dcnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (dcnt_q[k] == DW'(DEB_CYC - 1)) deb_d[k] = sync2_q[k];
        else dcnt_d[k] = dcnt_q[k] + 1'b1;
      end
    end
  end

  assign press = debp_q & ~deb_q;
  assign rise  = am_q & ~amp_q;

  always_comb begin
    rs_d    = rs_q;
    scnt_d  = scnt_q;
    led_d   = 1'b0;
    consume = 3'b000;
    if (rise) begin
      rs_d    = R_RING;
      scnt_d  = '0;
      consume = press;
    end else begin
      unique case (rs_q)
        R_RING: begin
          consume = press;
          if (press[1] | press[2]) begin
            rs_d = R_OFF;
          end else if (press[0]) begin
            rs_d   = R_SNOOZE;
            scnt_d = '0;
          end else if (sec_tick) begin
            if (scnt_q == SW'(RING_SEC - 1)) begin
              rs_d = R_OFF;
            end else begin
              scnt_d = scnt_q + 1'b1;
              led_d  = ~led_q;
            end
          end else begin
            led_d = led_q;
          end
        end
        R_SNOOZE: begin
          if (press[1]) begin
            rs_d       = R_OFF;
            consume[1] = 1'b1;
          end else if (sec_tick) begin
            if (scnt_q == SW'(SNOOZE_SEC - 1)) begin
              rs_d   = R_RING;
              scnt_d = '0;
            end else begin
              scnt_d = scnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mchg   = press[2] & ~consume[2];
  assign mode_d = mchg ? mode_q + 2'd1 : mode_q;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      kst_d[k]  = kst_q[k];
      kcnt_d[k] = kcnt_q[k];
      es_d[k]   = 1'b0;
      el_d[k]   = 1'b0;
`ifdef WATCH_REPEAT_EN
      rpt_d[k]  = rpt_q[k];
`endif
      // A consumed press or a mode step swallows this key until released
      if (consume[k] || mchg) begin
        kst_d[k] = K_WAIT;
      end else begin
        unique case (kst_q[k])
          K_IDLE: begin
            if (press[k]) begin
              kst_d[k]  = K_PRESS;
              kcnt_d[k] = '0;
            end
          end
          K_PRESS: begin
            if (deb_q[k]) begin
              es_d[k]  = 1'b1;
              kst_d[k] = K_IDLE;
            end else if (kcnt_q[k] == LW'(LONG_CYC - 2)) begin
              el_d[k]  = 1'b1;
              kst_d[k] = K_HELD;
`ifdef WATCH_REPEAT_EN
              rpt_d[k] = '0;
`endif
            end else begin
              kcnt_d[k] = kcnt_q[k] + 1'b1;
            end
          end
          K_HELD: begin
            if (deb_q[k]) begin
              kst_d[k] = K_IDLE;
            end
`ifdef WATCH_REPEAT_EN
            else if (rpt_q[k] == RW'(REPEAT_CYC - 1)) begin
              el_d[k]  = 1'b1;
              rpt_d[k] = '0;
            end else begin
              rpt_d[k] = rpt_q[k] + 1'b1;
            end
`endif
          end
          default: begin
            if (deb_q[k]) kst_d[k] = K_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      deb_q   <= 3'b111;
      debp_q  <= 3'b111;
      dcnt_q  <= '0;
      am_q    <= 1'b0;
      amp_q   <= 1'b0;
      kst_q   <= '{K_IDLE, K_IDLE};
      kcnt_q  <= '0;
      es_q    <= '0;
      el_q    <= '0;
      mode_q  <= '0;
      hex_q   <= '0;
      rs_q    <= R_OFF;
      scnt_q  <= '0;
      led_q   <= 1'b0;
      ring_q  <= 1'b0;
`ifdef WATCH_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      debp_q  <= deb_q;
      dcnt_q  <= dcnt_d;
      am_q    <= alarm_match;
      amp_q   <= am_q;
      kst_q   <= kst_d;
      kcnt_q  <= kcnt_d;
      es_q    <= es_d;
      el_q    <= el_d;
      mode_q  <= mode_d;
      hex_q   <= (rs_d == R_RING) ? 2'd3 : mode_d;
      rs_q    <= rs_d;
      scnt_q  <= scnt_d;
      led_q   <= led_d;
      ring_q  <= (rs_d == R_RING);
`ifdef WATCH_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign mode      = mode_q;
  assign evt_short = es_q;
  assign evt_long  = el_q;
  assign ringing   = ring_q;
  assign ring_led  = led_q;
  assign hex_sel   = hex_q;

endmodule
